// File: rtl/ysyx_mdu_pkg.sv
// Shared types and decode helpers for the M-extension multiply/divide unit.
package ysyx_mdu_pkg;

    localparam int unsigned MDU_XLEN_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return op[2];
    endfunction

    function automatic logic is_rem(mdu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed1(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed2(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic want_high(mdu_op_e op);
        return !op[2] && (op != OP_MUL);
    endfunction

endpackage

// File: rtl/ysyx_mdu_iter.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
module ysyx_mdu_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                div_i,
    input  logic                calc_i,
    input  logic [XLEN-1:0]     opa_i,
    input  logic [XLEN-1:0]     opb_i,
    output logic                last_c_o,
    output logic [2*XLEN-1:0]   acc_nxt_c_o
);
    localparam int unsigned DW = 2 * XLEN;

    logic [DW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_diff;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
        div_diff = acc_q[DW-1:XLEN-1] - {1'b0, b_q};
        if (div_q) begin
            acc_nxt_c_o = div_diff[XLEN] ? {acc_q[DW-2:0], 1'b0}
                                         : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_nxt_c_o = {mul_sum, acc_q[XLEN-1:1]};
        end
        last_c_o = (cnt_q == '0);
        if (start_i) begin
            div_d = div_i;
            cnt_d = CNT_W'(XLEN - 1);
            b_d   = div_i ? opb_i : opa_i;
            acc_d = {{XLEN{1'b0}}, (div_i ? opa_i : opb_i)};
        end else if (calc_i) begin
            acc_d = acc_nxt_c_o;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_exu_mdu.sv
// RV M-extension multiply/divide unit with valid/ready handshake and flush.
// YSYX_MDU_FAST_MUL_EN: single-cycle combinational multiplier for MUL* ops.
module ysyx_exu_mdu
    import ysyx_mdu_pkg::*;
#(
    parameter int unsigned XLEN  = MDU_XLEN_DEF,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prev_valid,
    output logic            ready_o,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      rd,
    input  logic            flush,
    output logic            valid_o,
    input  logic            next_ready,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      rd_o,
    output logic            busy_o
);
    localparam int unsigned DW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e      state_q, state_d;
    mdu_op_e         op_q, op_d, op_in;
    logic [3:0]      rd_q, rd_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, busy_q;

    logic            s1, s2, acc_neg, accept, div_zero, div_ovf, special, fast, iter_start;
    logic [XLEN-1:0] mag1, mag2, special_res, fast_res, iter_res, iter_sel;
    logic            iter_last;
    logic [DW-1:0]   iter_acc, iter_full;

    assign ready_o  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & next_ready);
    assign valid_o  = valid_q;
    assign busy_o   = busy_q;
    assign result_o = result_q;
    assign rd_o     = rd_q;

    // Operand decode, sign stripping and accept-time special cases
    always_comb begin
        op_in    = mdu_op_e'(op);
        s1       = is_signed1(op_in) & src1[XLEN-1];
        s2       = is_signed2(op_in) & src2[XLEN-1];
        mag1     = s1 ? -src1 : src1;
        mag2     = s2 ? -src2 : src2;
        acc_neg  = is_rem(op_in) ? s1 : (s1 ^ s2);
        accept   = prev_valid & ready_o & ~flush;
        div_zero = is_div(op_in) & (src2 == '0);
        div_ovf  = ((op_in == OP_DIV) | (op_in == OP_REM)) & (src1 == MIN_NEG) & (&src2);
        special  = div_zero | div_ovf;
        if (div_zero) begin
            special_res = is_rem(op_in) ? src1 : '1;
        end else begin
            special_res = (op_in == OP_DIV) ? src1 : '0;
        end
    end

`ifdef YSYX_MDU_FAST_MUL_EN
    logic [DW-1:0] fast_prod, fast_full;

    always_comb begin
        fast      = ~is_div(op_in);
        fast_prod = DW'(mag1) * DW'(mag2);
        fast_full = (s1 ^ s2) ? -fast_prod : fast_prod;
        fast_res  = want_high(op_in) ? fast_full[DW-1:XLEN] : fast_full[XLEN-1:0];
    end
`else
    assign fast     = 1'b0;
    assign fast_res = '0;
`endif

    assign iter_start = accept & ~special & ~fast;

    ysyx_mdu_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk         (clk),
        .rst         (rst),
        .start_i     (iter_start),
        .div_i       (is_div(op_in)),
        .calc_i      (state_q == ST_CALC),
        .opa_i       (mag1),
        .opb_i       (mag2),
        .last_c_o    (iter_last),
        .acc_nxt_c_o (iter_acc)
    );

    // Re-apply sign to the unsigned iterative result
    always_comb begin
        iter_full = neg_q ? -iter_acc : iter_acc;
        iter_sel  = is_rem(op_q) ? iter_acc[DW-1:XLEN] : iter_acc[XLEN-1:0];
        if (is_div(op_q)) begin
            iter_res = neg_q ? -iter_sel : iter_sel;
        end else begin
            iter_res = want_high(op_q) ? iter_full[DW-1:XLEN] : iter_full[XLEN-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (iter_last) begin
                    state_d  = ST_DONE;
                    result_d = (rd_q == '0) ? '0 : iter_res;
                end
            end
            ST_DONE: begin
                if (flush || next_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        // Accept overrides the DONE->IDLE hand-off for back-to-back issue
        if (accept) begin
            op_d  = op_in;
            rd_d  = rd;
            neg_d = acc_neg;
            if (special || fast) begin
                state_d  = ST_DONE;
                result_d = (rd == '0) ? '0 : (special ? special_res : fast_res);
            end else begin
                state_d = ST_CALC;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= (state_d == ST_DONE);
            busy_q   <= (state_d == ST_CALC);
        end
    end

endmodule

// File: tb/tb_ysyx_exu_mdu.sv
// Self-checking bench for ysyx_exu_mdu: directed plan cases plus randomized ops vs. arithmetic model.
module tb_ysyx_exu_mdu;

    logic        clk, rst, prev_valid, ready_o, flush, valid_o, next_ready, busy_o;
    logic [2:0]  op;
    logic [31:0] src1, src2, result_o;
    logic [3:0]  rd, rd_o;

    int vectors     = 0;
    int miscompares = 0;

`ifdef YSYX_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    ysyx_exu_mdu dut (
        .clk        (clk),
        .rst        (rst),
        .prev_valid (prev_valid),
        .ready_o    (ready_o),
        .op         (op),
        .src1       (src1),
        .src2       (src2),
        .rd         (rd),
        .flush      (flush),
        .valid_o    (valid_o),
        .next_ready (next_ready),
        .result_o   (result_o),
        .rd_o       (rd_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] r);
        longint      sa, sb;
        logic [63:0] p;
        logic [31:0] res;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = 32'h0;
        case (o)
            3'd0: res = a * b;
            3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'h0, b})); res = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; res = p[63:32]; end
            3'd4: res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
            3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: res = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            default: res = (b == 0) ? a : a % b;
        endcase
        return (r == 4'd0) ? 32'h0 : res;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation; returns one step after the accepting edge (cycle T+1)
    task automatic present(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] r, input logic nr);
        op = o; src1 = a; src2 = b; rd = r; prev_valid = 1'b1; next_ready = nr;
        #1;
        @(posedge clk); #1;
        prev_valid = 1'b0; next_ready = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (valid_o !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        next_ready = 1'b1;
        @(posedge clk); #1;
        next_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] r);
        int lat;
        present(o, a, b, r, 1'b0);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat(o, a, b)));
        check(tag, result_o, model(o, a, b, r));
        check({tag, "_rd"}, {28'h0, rd_o}, {28'h0, r});
        consume();
        check({tag, "_drop"}, {31'h0, valid_o}, 32'h0);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        logic [3:0]  rr;

        clk = 0; rst = 1; prev_valid = 0; flush = 0; next_ready = 0;
        op = 0; src1 = 0; src2 = 0; rd = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, valid_o}, 32'h0);
        check("rst_result", result_o, 32'h0);
        check("rst_rd", {28'h0, rd_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        check("rst_ready", {31'h0, ready_o}, 32'h1);
        rst = 0;
        @(posedge clk); #1;

        run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 4'd1);
        run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
        run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h2, 4'd4);
        run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 4'd5);
        run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 4'd6);
        run_op("divu", 3'd5, 32'd100, 32'd7, 4'd7);
        run_op("remu", 3'd7, 32'd100, 32'd7, 4'd8);
        run_op("divu_z", 3'd5, 32'd5, 32'd0, 4'd9);
        run_op("rem_z", 3'd6, 32'd5, 32'd0, 4'd10);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd12);
        run_op("mul_rd0", 3'd0, 32'd6, 32'd7, 4'd0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rr = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op("rand", ro, ra, rb, rr);
        end

        // Flush kills an in-flight divide
        present(3'd5, 32'd1000, 32'd7, 4'd2, 1'b0);
        seen = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            if (valid_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_ready", {31'h0, ready_o}, 32'h1);
        check("flush_busy", {31'h0, busy_o}, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_no_valid", {31'h0, seen}, 32'h0);
        run_op("div_after_flush", 3'd4, 32'd9, 32'd3, 4'd3);

        // Flush wins over a same-cycle accept
        op = 3'd5; src1 = 32'd50; src2 = 32'd5; rd = 4'd1; prev_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        prev_valid = 1'b0; flush = 1'b0;
        seen = busy_o | valid_o;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("flush_beats_accept", {31'h0, seen}, 32'h0);

        // Asynchronous reset mid-CALC
        present(3'd5, 32'd12345, 32'd11, 4'd9, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'h0, busy_o}, 32'h1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy_o}, 32'h0);
        check("arst_result", result_o, 32'h0);
        check("arst_rd", {28'h0, rd_o}, 32'h0);
        check("arst_valid", {31'h0, valid_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_ready", {31'h0, ready_o}, 32'h1);

        // Stall in DONE, then back-to-back issue on the consuming cycle
        present(3'd0, 32'd6, 32'd7, 4'd4, 1'b0);
        wait_valid(lat);
        check("b2b1_lat", 32'(lat), 32'(MUL_LAT));
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {31'h0, valid_o}, 32'h1);
            check("stall_result", result_o, 32'd42);
            check("stall_rd", {28'h0, rd_o}, 32'd4);
            @(posedge clk); #1;
        end
        op = 3'd0; src1 = 32'd3; src2 = 32'd3; rd = 4'd5; prev_valid = 1'b1; next_ready = 1'b1;
        #1;
        check("b2b_ready", {31'h0, ready_o}, 32'h1);
        @(posedge clk); #1;
        prev_valid = 1'b0; next_ready = 1'b0;
        wait_valid(lat);
        check("b2b2_lat", 32'(lat), 32'(MUL_LAT));
        check("b2b2_result", result_o, 32'd9);
        check("b2b2_rd", {28'h0, rd_o}, 32'd5);
        consume();
        check("b2b2_drop", {31'h0, valid_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_exu_mdu.md
# ysyx_exu_mdu

Multi-cycle multiply/divide unit implementing the RV M-extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for the execute stage. It sits beside the EXU ALU and receives operands from the IDU pipe on the same prev_valid/ready_o and valid_o/next_ready handshake. It returns one result per accepted operation and supports a pipeline flush that kills an in-flight operation.

## Interface
- XLEN, 32, datapath width in bits (power of two, at least 8)
- CNT_W, $clog2(XLEN), iteration counter width (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- prev_valid  in  1  upstream has an operation
- ready_o  out  1  unit can accept this cycle
- op  in  3  funct3 of the M instruction (0=MUL … 7=REMU)
- src1, src2  in  XLEN  rs1 and rs2 operands
- rd  in  4  destination register index
- flush  in  1  kill the in-flight or completed operation
- valid_o  out  1  result_o is valid
- next_ready  in  1  downstream consumes the result
- result_o  out  XLEN  result; forced to 0 when rd_o == 0
- rd_o  out  4  registered destination index
- busy_o  out  1  state is CALC

## Operation
- States: IDLE, CALC, DONE.
- Accept: prev_valid & ready_o. At accept, latch op, rd, the magnitudes of both operands, and the sign flags. Signedness per op:
  - MULH: both signed
  - MULHSU: src1 signed only
  - DIV/REM: both signed
  - All others: unsigned
- Special cases resolved at accept (IDLE→DONE, no CALC):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give src1.
  - Signed overflow (src1 = 1<<(XLEN-1), src2 = all ones): DIV gives src1; REM gives 0.
- Multiply: shift-add over XLEN iterations on a 2·XLEN product.
  - MUL returns the low half.
  - MULH* return the high half after conditional two's-complement negation of the full product.
- Divide: restoring shift-subtract over XLEN iterations.
  - Quotient sign = sign1 XOR sign2 (signed ops).
  - Remainder sign = sign1.
- CALC: counter loads XLEN-1 and decrements once per cycle. Leave for DONE after the iteration at counter 0.
- DONE: valid_o = 1 and result_o held stable until next_ready.
- ready_o = (state == IDLE) | (state == DONE & next_ready). This permits back-to-back operations with no bubble.
- flush: next state is IDLE and valid_o drops the following cycle.
  - flush beats a same-cycle accept; the operation is not latched.
  - A DONE result under flush is discarded even if next_ready is high.
- Reset values: state IDLE, valid_o 0, result_o 0, rd_o 0, busy_o 0. ready_o is 1 after reset.
- Reset mid-CALC discards the operation immediately (asynchronous).

## Timing
- Accept at cycle T.
- Iterative op: CALC during T+1..T+XLEN; valid_o first high at T+XLEN+1.
- Special-case div: valid_o high at T+1.
- With YSYX_MDU_FAST_MUL_EN, multiply: valid_o high at T+1.
- Each result is presented exactly once. valid_o stays high across stall cycles (next_ready = 0) with result_o and rd_o unchanged.
- Back-to-back: a new accept in the same cycle as DONE & next_ready begins CALC at the next cycle.

## Configuration
- `YSYX_MDU_FAST_MUL_EN`
  - Defined: all four multiply ops are computed with a single-cycle combinational 2·XLEN multiplier and go IDLE→DONE (latency 1). Divide ops are unchanged.
  - Undefined: multiply uses the iterative shift-add path (latency XLEN+1) and no hardware multiplier is inferred.

## Structure
- Package ysyx_mdu_pkg holds:
  - the op enum (funct3 encodings MUL..REMU)
  - the state enum
  - helper functions is_div(op), is_signed1(op), is_signed2(op), want_high(op)
- Sub-module ysyx_mdu_iter holds the shared iterative datapath: 2·XLEN accumulator/remainder, shift register, counter, and mode input mul/div. ysyx_exu_mdu keeps the FSM, handshake, sign handling, special cases and the fast-multiply path.

## Test plan
- MUL src1 = 7, src2 = 0xFFFFFFFD → result 0xFFFFFFEB, valid_o at T+33 (fast-mul off) or T+1 (fast-mul on).
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH on the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF at T+1. REM 5 / 0 → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM → 0, both at T+1.
- Start DIVU; assert flush at T+10 → valid_o never rises, ready_o is 1 at T+11, and the next DIV 9 / 3 returns 3. Separately, assert rst at T+5 → all outputs return to reset values immediately.
- Hold next_ready = 0 for 4 cycles in DONE → result is stable. Then issue back-to-back MULs (6×7, then 3×3) with next_ready = 1 → results 42 then 9, the second accepted in the same cycle the first is consumed. rd = 0 → result_o = 0.
